// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the blocking data cache.
// Stores write-back lines and answers fills after a fixed latency.
module dcache_mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int DAT_W     = 128,
  parameter int BEATS     = 4,
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcache__mem_valid_r,
  input  logic              dcache__mem_sop_r,
  input  logic              dcache__mem_eop_r,
  input  logic              dcache__mem_wrbk_r,
  input  logic [ADDR_W-1:0] dcache__mem_addr_r,
  input  logic              dcache__mem_dat_valid_r,
  input  logic [DAT_W-1:0]  dcache__mem_dat_r,
  output logic              mem__dcache_valid_r,
  output logic              mem__dcache_sop_r,
  output logic              mem__dcache_eop_r,
  output logic [DAT_W-1:0]  mem__dcache_data_r,
  output logic              busy_r,
  output logic              err_r,
  output logic [15:0]       fill_cnt_r,
  output logic [15:0]       wbk_cnt_r
);

  localparam int BYTES_LINE = BEATS * DAT_W / 8;
  localparam int OFF_W  = $clog2(BYTES_LINE);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = $clog2(LATENCY + 1);
  localparam int REP    = DAT_W / ADDR_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BYTES_LINE - 1);
  localparam logic [ADDR_W-1:0] BEAT_STEP = ADDR_W'(DAT_W / 8);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WB        = 2'd1;
  localparam logic [1:0] ST_FILL_WAIT = 2'd2;
  localparam logic [1:0] ST_FILL_SEND = 2'd3;

  typedef logic [BEATS-1:0][DAT_W-1:0] line_t;

  logic [1:0]           state_r;
  logic [BEAT_W-1:0]    beat_r;
  logic [LAT_W-1:0]     lat_r;
  logic [IDX_W-1:0]     idx_r;
  logic [ADDR_W-1:0]    base_r;
  logic [MEM_LINES-1:0] written_r;
  line_t                wb_buf_r;
  line_t                mem [MEM_LINES];

  logic              st_idle;
  logic              st_wb;
  logic              st_fw;
  logic              st_fs;
  logic              req_sop;
  logic              wb_start;
  logic              fill_start;
  logic              idle_err;
  logic              wb_beat;
  logic [BEAT_W-1:0] cur_beat;
  logic              cur_last;
  logic              wb_end;
  logic              commit;
  logic              wb_bad;
  logic              wb_clash;
  logic              fill_clash;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  line_idx;
  logic [ADDR_W-1:0] pat_word;
  logic [DAT_W-1:0]  fill_word;
  line_t             line_wr;

  assign st_idle = (state_r == ST_IDLE);
  assign st_wb   = (state_r == ST_WB);
  assign st_fw   = (state_r == ST_FILL_WAIT);
  assign st_fs   = (state_r == ST_FILL_SEND);

  assign req_idx = dcache__mem_addr_r[OFF_W +: IDX_W];
  assign req_sop = dcache__mem_valid_r & dcache__mem_sop_r;

  assign wb_start   = st_idle & req_sop & dcache__mem_wrbk_r
                    & dcache__mem_dat_valid_r;
  assign fill_start = st_idle & req_sop & ~dcache__mem_wrbk_r;
  assign idle_err   = st_idle & dcache__mem_valid_r
                    & (~dcache__mem_sop_r
                       | (dcache__mem_wrbk_r & ~dcache__mem_dat_valid_r));

  // The first write-back beat arrives in IDLE and is beat 0.
  assign wb_beat  = wb_start | (st_wb & dcache__mem_dat_valid_r);
  assign cur_beat = st_idle ? '0 : beat_r;
  assign cur_last = (cur_beat == LAST_BEAT);
  assign wb_end   = wb_beat & (dcache__mem_eop_r | cur_last);
  assign commit   = wb_beat & dcache__mem_eop_r & cur_last;
  assign wb_bad   = wb_beat & (dcache__mem_eop_r ^ cur_last);
  assign wb_clash   = st_wb & req_sop;
  assign fill_clash = (st_fw | st_fs) & dcache__mem_valid_r;
  assign line_idx   = st_idle ? req_idx : idx_r;

  assign busy_r = ~st_idle;

  assign pat_word  = base_r + (ADDR_W'(beat_r) * BEAT_STEP);
  assign fill_word = written_r[idx_r] ? mem[idx_r][beat_r]
                                      : {REP{pat_word}};

  // Complete line image: buffered beats plus the final beat in flight.
  always_comb begin
    line_wr = wb_buf_r;
    line_wr[BEATS-1] = dcache__mem_dat_r;
  end

  // Staging buffer so a bad or aborted write-back never touches the array.
  always_ff @(posedge clk) begin
    if (wb_beat) begin
      wb_buf_r[cur_beat] <= dcache__mem_dat_r;
    end
  end

  // Line array: whole line committed on a well-formed last beat.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      mem[line_idx] <= line_wr;
    end
  end

  // Control FSM, fill beat generation, status and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r             <= ST_IDLE;
      beat_r              <= '0;
      lat_r               <= '0;
      idx_r               <= '0;
      base_r              <= '0;
      written_r           <= '0;
      mem__dcache_valid_r <= 1'b0;
      mem__dcache_sop_r   <= 1'b0;
      mem__dcache_eop_r   <= 1'b0;
      mem__dcache_data_r  <= '0;
      err_r               <= 1'b0;
      fill_cnt_r          <= '0;
      wbk_cnt_r           <= '0;
    end else begin
      mem__dcache_valid_r <= 1'b0;
      mem__dcache_sop_r   <= 1'b0;
      mem__dcache_eop_r   <= 1'b0;
      if (idle_err || wb_bad || wb_clash || fill_clash) begin
        err_r <= 1'b1;
      end
      if (commit) begin
        written_r[line_idx] <= 1'b1;
        if (wbk_cnt_r != 16'hFFFF) begin
          wbk_cnt_r <= wbk_cnt_r + 16'd1;
        end
      end
      unique case (state_r)
        ST_IDLE: begin
          unique case (1'b1)
            wb_start: begin
              idx_r   <= req_idx;
              beat_r  <= BEAT_W'(1);
              state_r <= wb_end ? ST_IDLE : ST_WB;
            end
            fill_start: begin
              idx_r   <= req_idx;
              base_r  <= dcache__mem_addr_r & ~OFF_MASK;
              lat_r   <= LAT_W'(LATENCY);
              state_r <= ST_FILL_WAIT;
            end
            default: ;
          endcase
        end
        ST_WB: begin
          if (wb_beat) begin
            beat_r <= beat_r + BEAT_W'(1);
            if (wb_end) begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_FILL_WAIT: begin
          if (lat_r == LAT_W'(1)) begin
            beat_r  <= '0;
            state_r <= ST_FILL_SEND;
          end else begin
            lat_r <= lat_r - LAT_W'(1);
          end
        end
        ST_FILL_SEND: begin
          mem__dcache_valid_r <= 1'b1;
          mem__dcache_sop_r   <= (beat_r == '0);
          mem__dcache_eop_r   <= (beat_r == LAST_BEAT);
          mem__dcache_data_r  <= fill_word;
          beat_r              <= beat_r + BEAT_W'(1);
          if (beat_r == LAST_BEAT) begin
            state_r <= ST_IDLE;
            if (fill_cnt_r != 16'hFFFF) begin
              fill_cnt_r <= fill_cnt_r + 16'd1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder.
// Table of pattern fills plus write-back / error / reset sequences.
module tb_dcache_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         sop;
  logic         eop;
  logic         wrbk;
  logic [31:0]  addr;
  logic         dat_valid;
  logic [127:0] dat;
  logic         o_valid;
  logic         o_sop;
  logic         o_eop;
  logic [127:0] o_data;
  logic         busy;
  logic         err;
  logic [15:0]  fill_cnt;
  logic [15:0]  wbk_cnt;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dcache_mem_responder dut (
    .clk                     (clk),
    .rst                     (rst),
    .dcache__mem_valid_r     (valid),
    .dcache__mem_sop_r       (sop),
    .dcache__mem_eop_r       (eop),
    .dcache__mem_wrbk_r      (wrbk),
    .dcache__mem_addr_r      (addr),
    .dcache__mem_dat_valid_r (dat_valid),
    .dcache__mem_dat_r       (dat),
    .mem__dcache_valid_r     (o_valid),
    .mem__dcache_sop_r       (o_sop),
    .mem__dcache_eop_r       (o_eop),
    .mem__dcache_data_r      (o_data),
    .busy_r                  (busy),
    .err_r                   (err),
    .fill_cnt_r              (fill_cnt),
    .wbk_cnt_r               (wbk_cnt)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } fill_vec_t;

  fill_vec_t tbl [4];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; wrbk = 1'b0;
    dat_valid = 1'b0; dat = '0;
  endtask

  // Issue a fill and check beat timing, flags and data.
  // extra_k >= 1 injects a second request k cycles after acceptance.
  task automatic run_fill(input logic [31:0] a,
                          input logic [127:0] exp [4],
                          input int extra_k);
    int b;
    @(negedge clk);
    valid = 1'b1; sop = 1'b1; eop = 1'b1; wrbk = 1'b0;
    dat_valid = 1'b0; addr = a;
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      b = k - 5;
      if (b >= 0 && b < 4) begin
        chk("fill_ctl", {o_valid, o_sop, o_eop},
            {1'b1, (b == 0), (b == 3)});
        chk("fill_data", o_data, exp[b]);
      end else begin
        chk("fill_idle", {o_valid, o_sop, o_eop}, 3'b000);
      end
      if (k == 2) chk("fill_busy", busy, 1'b1);
      valid = (k == extra_k);
      sop   = (k == extra_k);
      addr  = (k == extra_k) ? 32'h0000_9000 : a;
    end
  endtask

  task automatic send_wb(input logic [31:0] a,
                         input logic [127:0] d [4],
                         input int gap_after, input int eop_beat);
    for (int b = 0; b <= eop_beat; b++) begin
      @(negedge clk);
      valid = (b == 0); sop = (b == 0); wrbk = 1'b1;
      addr = a; dat_valid = 1'b1; dat = d[b];
      eop = (b == eop_beat);
      if (b == gap_after) begin
        @(negedge clk);
        valid = 1'b0; sop = 1'b0; dat_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  function automatic void pat(input logic [31:0] w0,
                              output logic [127:0] e [4]);
    for (int i = 0; i < 4; i++) e[i] = {4{w0 + 32'(i * 16)}};
  endfunction

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp [4];
    logic [127:0] d [4];
    bit seen;

    tbl[0] = '{32'h0000_1040, 32'h0000_1040, 32'h0000_1050,
               32'h0000_1060, 32'h0000_1070};
    tbl[1] = '{32'h0000_107C, 32'h0000_1040, 32'h0000_1050,
               32'h0000_1060, 32'h0000_1070};
    tbl[2] = '{32'hFFFF_FFC0, 32'hFFFF_FFC0, 32'hFFFF_FFD0,
               32'hFFFF_FFE0, 32'hFFFF_FFF0};
    tbl[3] = '{32'h1234_5678, 32'h1234_5640, 32'h1234_5650,
               32'h1234_5660, 32'h1234_5670};

    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; wrbk = 1'b0;
    addr = '0; dat_valid = 1'b0; dat = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {o_valid, o_sop, o_eop}, 3'b000);
    chk("rst_data", o_data, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", {fill_cnt, wbk_cnt}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      exp[0] = {4{tbl[i].w0}};
      exp[1] = {4{tbl[i].w1}};
      exp[2] = {4{tbl[i].w2}};
      exp[3] = {4{tbl[i].w3}};
      run_fill(tbl[i].a, exp, -1);
      chk("tbl_fill_cnt", fill_cnt, 16'(i + 1));
      chk("tbl_err", err, 1'b0);
    end

    d[0] = 128'hD0D0_0000_1111_2222_3333_4444_5555_0000;
    d[1] = 128'hD1D1_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    d[2] = 128'hD2D2_0123_4567_89AB_CDEF_FEDC_BA98_0002;
    d[3] = 128'hD3D3_5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_0003;
    send_wb(32'h0000_2000, d, 1, 3);
    run_fill(32'h0000_2000, d, -1);
    chk("wb_cnt", wbk_cnt, 16'd1);
    chk("wb_err", err, 1'b0);
    chk("wb_fill_cnt", fill_cnt, 16'd5);
    run_fill(32'h0010_2000, d, -1);
    chk("alias_fill_cnt", fill_cnt, 16'd6);

    pat(32'h0000_3000, exp);
    run_fill(32'h0000_3000, exp, 1);
    chk("clash_err", err, 1'b1);
    chk("clash_fill_cnt", fill_cnt, 16'd7);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst2_err", err, 1'b0);
    send_wb(32'h0000_4000, d, -1, 2);
    idle_in();
    @(negedge clk);
    chk("badwb_err", err, 1'b1);
    chk("badwb_cnt", wbk_cnt, 16'd0);
    chk("badwb_busy", busy, 1'b0);
    pat(32'h0000_4000, exp);
    run_fill(32'h0000_4000, exp, -1);
    chk("badwb_fill_cnt", fill_cnt, 16'd1);

    @(negedge clk);
    valid = 1'b1; sop = 1'b1; eop = 1'b1; wrbk = 1'b0;
    addr = 32'h0000_5000;
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_valid && o_sop) seen = 1'b1;
    end
    chk("rstfill_beat0_seen", seen, 1'b1);
    @(negedge clk);
    chk("rstfill_beat1", {o_valid, o_sop, o_eop}, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstfill_valid", o_valid, 1'b0);
    chk("rstfill_busy", busy, 1'b0);
    chk("rstfill_err", err, 1'b0);
    chk("rstfill_cnt", {fill_cnt, wbk_cnt}, 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("rstfill_quiet", o_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
